// File: rtl/cpu_pkg.sv
// Shared constants for the accumulator CPU control sequencer: opcodes, state
// encodings, ALU function codes and the per-cycle strobe bundle.
package cpu_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned ALU_W   = 2;

    localparam logic [OP_W-1:0] OP_NOR = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD = 3'b001;
    localparam logic [OP_W-1:0] OP_STA = 3'b010;
    localparam logic [OP_W-1:0] OP_JCC = 3'b011;
    localparam logic [OP_W-1:0] OP_LDA = 3'b100;
    localparam logic [OP_W-1:0] OP_JMP = 3'b101;
    localparam logic [OP_W-1:0] OP_JZ  = 3'b110;
    localparam logic [OP_W-1:0] OP_HLT = 3'b111;

    localparam logic [STATE_W-1:0] ST_FETCH   = 4'd0;
    localparam logic [STATE_W-1:0] ST_LOAD_RI = 4'd1;
    localparam logic [STATE_W-1:0] ST_DECODE  = 4'd2;
    localparam logic [STATE_W-1:0] ST_OPRD    = 4'd3;
    localparam logic [STATE_W-1:0] ST_EXEC    = 4'd4;
    localparam logic [STATE_W-1:0] ST_STORE   = 4'd5;
    localparam logic [STATE_W-1:0] ST_JUMP    = 4'd6;
    localparam logic [STATE_W-1:0] ST_HALT    = 4'd7;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = ST_FETCH,
        S_LOAD_RI = ST_LOAD_RI,
        S_DECODE  = ST_DECODE,
        S_OPRD    = ST_OPRD,
        S_EXEC    = ST_EXEC,
        S_STORE   = ST_STORE,
        S_JUMP    = ST_JUMP,
        S_HALT    = ST_HALT
    } state_e;

    localparam logic [ALU_W-1:0] ALU_NOR   = 2'b00;
    localparam logic [ALU_W-1:0] ALU_ADD   = 2'b01;
    localparam logic [ALU_W-1:0] ALU_PASSB = 2'b10;

    // Strobes that must be qualified by ce before leaving the controller
    typedef struct packed {
        logic load_ri;
        logic inc_pc;
        logic load_pc;
        logic we_mem;
        logic load_acc;
        logic load_carry;
        logic clear_carry;
    } strobe_t;

    // Instructions that read a memory operand before executing
    function automatic logic is_operand_op(input logic [OP_W-1:0] op);
        return (op == OP_NOR) || (op == OP_ADD) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Controller <-> datapath signal bundle. The step input exists only when
// CPU_CTRL_STEP_EN is defined.
interface cpu_ctrl_fsm_if;

    logic       ce;
    logic [2:0] code_op;
    logic       carry;
    logic       acc_zero;
`ifdef CPU_CTRL_STEP_EN
    logic       step;
`endif
    logic       load_RI;
    logic       inc_PC;
    logic       load_PC;
    logic       sel_adr;
    logic       we_mem;
    logic       load_ACC;
    logic       load_carry;
    logic       clear_carry;
    logic [1:0] alu_op;
    logic       halted;
    logic [3:0] state_o;

    modport master (
`ifdef CPU_CTRL_STEP_EN
        input  step,
`endif
        input  ce, code_op, carry, acc_zero,
        output load_RI, inc_PC, load_PC, sel_adr, we_mem, load_ACC,
               load_carry, clear_carry, alu_op, halted, state_o
    );

    modport slave (
`ifdef CPU_CTRL_STEP_EN
        output step,
`endif
        output ce, code_op, carry, acc_zero,
        input  load_RI, inc_PC, load_PC, sel_adr, we_mem, load_ACC,
               load_carry, clear_carry, alu_op, halted, state_o
    );

endinterface

// File: rtl/ctrl_wait_cnt.sv
// Memory-latency wait counter shared by FETCH and OPRD. zero_o exists only
// with CPU_CTRL_STEP_EN, where it marks the start of a fetch.
module ctrl_wait_cnt
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic ce_i,
    input  logic clr_i,
    input  logic inc_i,
`ifdef CPU_CTRL_STEP_EN
    output logic zero_o,
`endif
    output logic done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (ce_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CNT_W'(MEM_LAT - 1));
`ifdef CPU_CTRL_STEP_EN
    assign zero_o = (cnt_q == '0);
`endif

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator CPU.
// Optional single-step gating in FETCH is enabled by CPU_CTRL_STEP_EN.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    cpu_ctrl_fsm_if.master ctrl_if
);

    state_e           state_q;
    state_e           state_d;
    strobe_t          str_c;
    logic             sel_adr_c;
    logic [ALU_W-1:0] alu_op_c;
    logic             halted_c;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_done;
    logic             stall;

`ifdef CPU_CTRL_STEP_EN
    logic cnt_zero;

    // Hold at the very start of a fetch until a step request is seen
    assign stall = cnt_zero & ~ctrl_if.step;
`else
    assign stall = 1'b0;
`endif

    ctrl_wait_cnt #(.MEM_LAT(MEM_LAT)) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .ce_i   (ctrl_if.ce),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
`ifdef CPU_CTRL_STEP_EN
        .zero_o (cnt_zero),
`endif
        .done_o (cnt_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else if (ctrl_if.ce) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        str_c     = '0;
        sel_adr_c = 1'b0;
        alu_op_c  = ALU_NOR;
        halted_c  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (!stall) begin
                    if (cnt_done) begin
                        state_d = S_LOAD_RI;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_LOAD_RI: begin
                str_c.load_ri = 1'b1;
                str_c.inc_pc  = 1'b1;
                state_d       = S_DECODE;
            end
            S_DECODE: begin
                sel_adr_c = 1'b1;
                if (is_operand_op(ctrl_if.code_op)) begin
                    state_d = S_OPRD;
                    cnt_clr = 1'b1;
                end else begin
                    case (ctrl_if.code_op)
                        OP_STA: state_d = S_STORE;
                        OP_JMP: state_d = S_JUMP;
                        OP_JCC: begin
                            if (!ctrl_if.carry) begin
                                state_d = S_JUMP;
                            end else begin
                                str_c.clear_carry = 1'b1;
                                state_d           = S_FETCH;
                                cnt_clr           = 1'b1;
                            end
                        end
                        OP_JZ: begin
                            if (ctrl_if.acc_zero) begin
                                state_d = S_JUMP;
                            end else begin
                                state_d = S_FETCH;
                                cnt_clr = 1'b1;
                            end
                        end
                        default: state_d = S_HALT;
                    endcase
                end
            end
            S_OPRD: begin
                sel_adr_c = 1'b1;
                if (cnt_done) begin
                    state_d = S_EXEC;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_EXEC: begin
                sel_adr_c      = 1'b1;
                str_c.load_acc = 1'b1;
                case (ctrl_if.code_op)
                    OP_ADD: begin
                        alu_op_c         = ALU_ADD;
                        str_c.load_carry = 1'b1;
                    end
                    OP_LDA:  alu_op_c = ALU_PASSB;
                    default: alu_op_c = ALU_NOR;
                endcase
                state_d = S_FETCH;
                cnt_clr = 1'b1;
            end
            S_STORE: begin
                sel_adr_c    = 1'b1;
                str_c.we_mem = 1'b1;
                state_d      = S_FETCH;
                cnt_clr      = 1'b1;
            end
            S_JUMP: begin
                str_c.load_pc = 1'b1;
                state_d       = S_FETCH;
                cnt_clr       = 1'b1;
            end
            S_HALT: begin
                halted_c = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Strobes never fire in a ce-low cycle; selects and status follow the state
    assign ctrl_if.load_RI     = str_c.load_ri     & ctrl_if.ce;
    assign ctrl_if.inc_PC      = str_c.inc_pc      & ctrl_if.ce;
    assign ctrl_if.load_PC     = str_c.load_pc     & ctrl_if.ce;
    assign ctrl_if.we_mem      = str_c.we_mem      & ctrl_if.ce;
    assign ctrl_if.load_ACC    = str_c.load_acc    & ctrl_if.ce;
    assign ctrl_if.load_carry  = str_c.load_carry  & ctrl_if.ce;
    assign ctrl_if.clear_carry = str_c.clear_carry & ctrl_if.ce;
    assign ctrl_if.sel_adr     = sel_adr_c;
    assign ctrl_if.alu_op      = alu_op_c;
    assign ctrl_if.halted      = halted_c;
    assign ctrl_if.state_o     = STATE_W'(state_q);

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: DUT A uses MEM_LAT=1, DUT B uses MEM_LAT=3.
module tb_cpu_ctrl_fsm;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_ctrl_fsm_if bus_a ();
    cpu_ctrl_fsm_if bus_b ();

    cpu_ctrl_fsm #(.MEM_LAT(1)) u_dut_a (.clk(clk), .rst(rst), .ctrl_if(bus_a));
    cpu_ctrl_fsm #(.MEM_LAT(3)) u_dut_b (.clk(clk), .rst(rst), .ctrl_if(bus_b));

    int n_total = 0;
    int n_pass  = 0;

    // Observed bundle: {load_RI, inc_PC, load_PC, sel_adr, we_mem, load_ACC,
    //                   load_carry, clear_carry, alu_op[1:0], halted}
    localparam logic [10:0] V0     = 11'b00000000000;
    localparam logic [10:0] V_LR   = 11'b11000000000;
    localparam logic [10:0] V_SEL  = 11'b00010000000;
    localparam logic [10:0] V_CC   = 11'b00010001000;
    localparam logic [10:0] V_JMP  = 11'b00100000000;
    localparam logic [10:0] V_ST   = 11'b00011000000;
    localparam logic [10:0] V_NOR  = 11'b00010100000;
    localparam logic [10:0] V_ADD  = 11'b00010110010;
    localparam logic [10:0] V_LDA  = 11'b00010100100;
    localparam logic [10:0] V_HLT  = 11'b00000000001;
    localparam logic [10:0] M_CE0  = 11'b11101111000;

    localparam logic [3:0] F = 4'd0, LR = 4'd1, D = 4'd2, OP = 4'd3;
    localparam logic [3:0] EX = 4'd4, STO = 4'd5, JU = 4'd6, HA = 4'd7;

    localparam logic [3:0] B_ST [0:18] = '{F, F, F, F, F, LR, LR, D, D,
                                           OP, OP, OP, OP, OP, OP, EX, EX, F, F};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [10:0] obs(input bit sel_b);
        if (sel_b) begin
            return {bus_b.load_RI, bus_b.inc_PC, bus_b.load_PC, bus_b.sel_adr,
                    bus_b.we_mem, bus_b.load_ACC, bus_b.load_carry,
                    bus_b.clear_carry, bus_b.alu_op, bus_b.halted};
        end
        return {bus_a.load_RI, bus_a.inc_PC, bus_a.load_PC, bus_a.sel_adr,
                bus_a.we_mem, bus_a.load_ACC, bus_a.load_carry,
                bus_a.clear_carry, bus_a.alu_op, bus_a.halted};
    endfunction

    // One cycle: drive ce at the falling edge, check 1ns later, wait for next falling edge
    task automatic cyc(input string tag, input bit sel_b, input logic ce_v,
                       input logic [3:0] st, input logic [10:0] vec);
        logic [10:0] m;
        logic [3:0]  st_got;
        if (sel_b) bus_b.ce = ce_v; else bus_a.ce = ce_v;
        #1;
        m      = ce_v ? 11'h7FF : M_CE0;
        st_got = sel_b ? bus_b.state_o : bus_a.state_o;
        check({tag, ".st"}, 32'(st_got), 32'(st));
        check(tag, 32'(obs(sel_b) & m), 32'(vec & m));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst.st", 32'(bus_a.state_o), 32'(F));
        check("rst.out", 32'(obs(1'b0)), 32'(V0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_a(input logic [2:0] op, input logic c, input logic z);
        bus_a.code_op  = op;
        bus_a.carry    = c;
        bus_a.acc_zero = z;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus_a.ce = 1'b1; bus_b.ce = 1'b1;
        set_a(3'b001, 1'b0, 1'b0);
        bus_b.code_op = 3'b100; bus_b.carry = 1'b0; bus_b.acc_zero = 1'b0;
`ifdef CPU_CTRL_STEP_EN
        bus_a.step = 1'b1; bus_b.step = 1'b1;
`endif
        @(negedge clk);
        check("rst.b.st", 32'(bus_b.state_o), 32'(F));
        do_reset();

        // ADD
        cyc("add.c1", 0, 1, F, V0);  cyc("add.c2", 0, 1, LR, V_LR);
        cyc("add.c3", 0, 1, D, V_SEL); cyc("add.c4", 0, 1, OP, V_SEL);
        cyc("add.c5", 0, 1, EX, V_ADD); cyc("add.c6", 0, 1, F, V0);

        // NOR and LDA
        set_a(3'b000, 1'b0, 1'b0); do_reset();
        cyc("nor.c1", 0, 1, F, V0);  cyc("nor.c2", 0, 1, LR, V_LR);
        cyc("nor.c3", 0, 1, D, V_SEL); cyc("nor.c4", 0, 1, OP, V_SEL);
        cyc("nor.c5", 0, 1, EX, V_NOR); cyc("nor.c6", 0, 1, F, V0);
        set_a(3'b100, 1'b0, 1'b0); do_reset();
        cyc("lda.c1", 0, 1, F, V0);  cyc("lda.c2", 0, 1, LR, V_LR);
        cyc("lda.c3", 0, 1, D, V_SEL); cyc("lda.c4", 0, 1, OP, V_SEL);
        cyc("lda.c5", 0, 1, EX, V_LDA); cyc("lda.c6", 0, 1, F, V0);

        // STA
        set_a(3'b010, 1'b0, 1'b0); do_reset();
        cyc("sta.c1", 0, 1, F, V0);  cyc("sta.c2", 0, 1, LR, V_LR);
        cyc("sta.c3", 0, 1, D, V_SEL); cyc("sta.c4", 0, 1, STO, V_ST);
        cyc("sta.c5", 0, 1, F, V0);

        // JCC untaken (carry set) and taken
        set_a(3'b011, 1'b1, 1'b0); do_reset();
        cyc("jccn.c1", 0, 1, F, V0); cyc("jccn.c2", 0, 1, LR, V_LR);
        cyc("jccn.c3", 0, 1, D, V_CC); cyc("jccn.c4", 0, 1, F, V0);
        set_a(3'b011, 1'b0, 1'b0); do_reset();
        cyc("jcc.c1", 0, 1, F, V0);  cyc("jcc.c2", 0, 1, LR, V_LR);
        cyc("jcc.c3", 0, 1, D, V_SEL); cyc("jcc.c4", 0, 1, JU, V_JMP);
        cyc("jcc.c5", 0, 1, F, V0);

        // JMP, JZ taken and untaken
        set_a(3'b101, 1'b1, 1'b0); do_reset();
        cyc("jmp.c3pre", 0, 1, F, V0); cyc("jmp.c2", 0, 1, LR, V_LR);
        cyc("jmp.c3", 0, 1, D, V_SEL); cyc("jmp.c4", 0, 1, JU, V_JMP);
        set_a(3'b110, 1'b0, 1'b1); do_reset();
        cyc("jz.c1", 0, 1, F, V0); cyc("jz.c2", 0, 1, LR, V_LR);
        cyc("jz.c3", 0, 1, D, V_SEL); cyc("jz.c4", 0, 1, JU, V_JMP);
        set_a(3'b110, 1'b1, 1'b0); do_reset();
        cyc("jzn.c1", 0, 1, F, V0); cyc("jzn.c2", 0, 1, LR, V_LR);
        cyc("jzn.c3", 0, 1, D, V_SEL); cyc("jzn.c4", 0, 1, F, V0);

        // STA aborted by reset in DECODE, the cycle before STORE
        set_a(3'b010, 1'b0, 1'b0); do_reset();
        cyc("abort.c1", 0, 1, F, V0); cyc("abort.c2", 0, 1, LR, V_LR);
        #1;
        check("abort.c3", 32'(obs(1'b0)), 32'(V_SEL));
        #1 rst = 1'b1;
        #1;
        check("abort.async.st", 32'(bus_a.state_o), 32'(F));
        check("abort.async", 32'(obs(1'b0)), 32'(V0));
        @(negedge clk);
        cyc("abort.hold", 0, 1, F, V0);
        rst = 1'b0;
        cyc("abort.r1", 0, 1, F, V0); cyc("abort.r2", 0, 1, LR, V_LR);

        // HLT: halted from cycle 4, held for 20 cycles, cleared only by reset
        set_a(3'b111, 1'b0, 1'b0); do_reset();
        cyc("hlt.c1", 0, 1, F, V0); cyc("hlt.c2", 0, 1, LR, V_LR);
        cyc("hlt.c3", 0, 1, D, V_SEL);
        for (int i = 0; i < 21; i++) cyc("hlt.hold", 0, 1, HA, V_HLT);
        #2 rst = 1'b1;
        #1;
        check("hlt.rst.st", 32'(bus_a.state_o), 32'(F));
        check("hlt.rst", 32'(obs(1'b0)), 32'(V0));
        @(negedge clk);
        rst = 1'b0;

        // MEM_LAT=3 LDA with ce alternating 1,0,1,0
        do_reset();
        for (int i = 0; i < 19; i++) begin
            logic [10:0] vb;
            vb = (i == 6) ? V_LR : (i == 16) ? V_LDA :
                 ((B_ST[i] == D) || (B_ST[i] == OP)) ? V_SEL : V0;
            cyc($sformatf("ceb.k%0d", i + 1), 1, ((i % 2) == 0), B_ST[i], vb);
        end

`ifdef CPU_CTRL_STEP_EN
        // step low holds FETCH; a single pulse runs exactly one JMP
        bus_a.step = 1'b0;
        set_a(3'b101, 1'b0, 1'b0); do_reset();
        for (int i = 0; i < 10; i++) cyc("step.hold", 0, 1, F, V0);
        bus_a.step = 1'b1;
        cyc("step.go", 0, 1, F, V0);
        bus_a.step = 1'b0;
        cyc("step.lr", 0, 1, LR, V_LR); cyc("step.d", 0, 1, D, V_SEL);
        cyc("step.j", 0, 1, JU, V_JMP);
        for (int i = 0; i < 5; i++) cyc("step.stall", 0, 1, F, V0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Fetch/decode/execute sequencer for the 16-bit accumulator CPU. It drives the instruction register load strobe, the program counter, the address multiplexer, memory write and the ALU/accumulator controls from the 3-bit opcode and status flags. It sits between the instruction register (`code_op` source) and the datapath, gated by the same `ce` clock enable.

## Interface
- `MEM_LAT`, default 1: synchronous memory read latency in ce-cycles. Legal range is 1..4.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ce` in 1: clock enable. State, counter and all strobes are frozen or deasserted when low.
- `code_op` in 3: opcode from the instruction register. Valid from the DECODE state onward.
- `carry` in 1: carry flag.
- `acc_zero` in 1: accumulator == 0.
- `load_RI` out 1: instruction register load.
- `inc_PC` out 1: PC increment.
- `load_PC` out 1: PC load from the instruction address field.
- `sel_adr` out 1: memory address select. 0 selects PC; 1 selects the instruction address field.
- `we_mem` out 1: memory write (stores the accumulator).
- `load_ACC` out 1: accumulator load from the ALU.
- `load_carry` out 1: carry register load from the ALU.
- `clear_carry` out 1: synchronous carry clear.
- `alu_op` out 2: ALU function. 00 is NOR, 01 is ADD, 10 is PASS_B (memory data).
- `halted` out 1: high while in the HALT state.
- `state_o` out 4: current state encoding, for debug.

## Operation
- Opcodes: 000 NOR, 001 ADD, 010 STA, 011 JCC (jump if carry clear), 100 LDA, 101 JMP, 110 JZ (jump if acc_zero), 111 HLT.
- States and transitions. Each transition occurs only on a clock edge with `ce`=1.
  - FETCH: `sel_adr`=0. A wait counter counts `MEM_LAT` cycles, then goes to LOAD_RI.
  - LOAD_RI: `load_RI`=1 and `inc_PC`=1, then goes to DECODE.
  - DECODE: `sel_adr`=1. Next state by opcode:
    - NOR, ADD, LDA go to OPRD.
    - STA goes to STORE.
    - JMP goes to JUMP.
    - JCC goes to JUMP if `carry`=0. Otherwise it asserts `clear_carry`=1 and goes to FETCH.
    - JZ goes to JUMP if `acc_zero`=1, else to FETCH.
    - HLT goes to HALT.
  - OPRD: `sel_adr`=1. Waits `MEM_LAT` cycles, then goes to EXEC.
  - EXEC: `sel_adr`=1 and `load_ACC`=1. `alu_op` is 00 for NOR, 01 for ADD, 10 for LDA. `load_carry`=1 for ADD only. Goes to FETCH.
  - STORE: `sel_adr`=1 and `we_mem`=1, then goes to FETCH.
  - JUMP: `load_PC`=1, then goes to FETCH.
  - HALT: all strobes are 0 and `halted`=1. Only `rst` leaves this state.
- Strobe and output rules:
  - Strobes are decoded from the state and `code_op`, ANDed with `ce`. No strobe is asserted while `ce`=0.
  - `alu_op` is 00 outside EXEC.
- Wait counter:
  - Width is 2 bits; it clears when entering FETCH or OPRD.
  - It increments only while `ce`=1, and exit occurs when the count reaches `MEM_LAT`-1.

## Timing
- Reset values:
  - State is FETCH and the counter is 0.
  - `load_RI`, `inc_PC`, `load_PC`, `we_mem`, `load_ACC`, `load_carry`, `clear_carry` and `halted` are 0.
  - `sel_adr`=0, `alu_op`=00, and `state_o` is the FETCH code.
  - Outputs drop asynchronously with `rst`.
- Instruction length with `MEM_LAT`=1 and `ce` held high:
  - NOR, ADD and LDA take 5 cycles.
  - STA takes 4 cycles.
  - A taken jump takes 4 cycles; an untaken jump takes 3 cycles.
  - HLT takes 3 cycles to reach HALT.
  - Each extra `MEM_LAT` step adds 1 cycle per memory wait (FETCH, plus OPRD for operand instructions).
- `code_op` is sampled in DECODE only. The new instruction register value is visible one cycle after the LOAD_RI edge.
- `ce` low at any point, including mid-wait, freezes the state and counter with no lost or duplicated strobe.
- `rst` mid-instruction aborts the instruction immediately. No partial write occurs after `rst` rises.

## Configuration
- `CPU_CTRL_STEP_EN` defined:
  - Adds the input `step` (1 bit).
  - In FETCH with the counter at 0, the FSM holds until `step`=1 is sampled with `ce`=1. One instruction then executes.
  - A held-high `step` runs continuously.
- Undefined: the `step` port is absent and FETCH never stalls.

## Structure
- `cpu_pkg` holds:
  - opcode constants (`OP_NOR`..`OP_HLT`);
  - the state encoding localparams (4-bit);
  - the `alu_op` codes (`ALU_NOR`, `ALU_ADD`, `ALU_PASSB`).
- One sub-module, `ctrl_wait_cnt`: the `MEM_LAT` latency counter with clear, ce-gated increment and a `done` flag. It is instantiated once and shared by FETCH and OPRD.

## Test plan
- Reset, then run `ADD` (001) with `MEM_LAT`=1 and `ce`=1 → strobe sequence:
  - `load_RI` and `inc_PC` at cycle 2;
  - `sel_adr`=1 at cycles 3–5;
  - `load_ACC`, `load_carry` and `alu_op`=01 at cycle 5;
  - back in FETCH at cycle 6.
- JCC with `carry`=1 → `clear_carry` for one cycle in DECODE, `load_PC` never asserted. JCC with `carry`=0 → `load_PC`=1 at cycle 4.
- `MEM_LAT`=3 with `LDA`, and `ce` toggling 1,0,1,0 → FETCH lasts exactly 3 ce-high cycles, and each strobe is high only in ce-high cycles. LDA takes 9 ce-high cycles in total.
- STA, with `rst` asserted in the cycle before STORE → `we_mem` stays 0, the state returns to FETCH, and all outputs are 0.
- HLT (111) → `halted`=1 from cycle 4 and remains there for 20 cycles with all strobes 0. Only `rst` clears it.
- With `CPU_CTRL_STEP_EN`: `step` held 0 → the FSM stays in FETCH for 10 cycles. A one-cycle `step` pulse → exactly one JMP executes, then the FSM stalls in FETCH.
